// File: rtl/video_capture.sv
// video_capture: receiver for the SoC videoSync/videoPixel stream.
//
// Classifies sync pulses by length (glitch / hsync / vsync), walks a frame FSM
// (WAIT_VSYNC -> VBLANK -> HBACK -> CAPTURE -> LINE_WAIT ...) and packs sampled
// monochrome pixels, MSB first, into an internal byte buffer readable through a
// registered read port.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   videoSync   sync from the SoC, active high
//   videoPixel  pixel data from the SoC
//   rdAddr      buffer read address
//   rdData      buffer byte, registered, 1-cycle read latency (0 when out of range)
//   frameDone   1-cycle pulse when a full frame has been stored
//   frameCount  completed-frame counter, wraps 255 -> 0
//   capturing   high while inside the active area of a frame
//   lineError   sticky short-line flag, cleared on the next vsync
//   frameCrc    (VIDEO_CAPTURE_CRC_EN only) CRC-16/CCITT of the bytes written
//               during the last completed frame
//
// Optional feature macro: VIDEO_CAPTURE_CRC_EN adds the frameCrc output and its
// CRC logic. Without it the block has no CRC port or logic.

module video_capture #(
    parameter int unsigned H_PIXELS  = 64,
    parameter int unsigned V_LINES   = 32,
    parameter int unsigned PIXEL_DIV = 4,
    parameter int unsigned H_BACK    = 16,
    parameter int unsigned V_BACK    = 2,
    parameter int unsigned HSYNC_MIN = 4,
    parameter int unsigned VSYNC_MIN = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   videoSync,
    input  logic                                   videoPixel,
    input  logic [$clog2(H_PIXELS/8*V_LINES)-1:0]  rdAddr,
    output logic [7:0]                             rdData,
    output logic                                   frameDone,
    output logic [7:0]                             frameCount,
    output logic                                   capturing,
    output logic                                   lineError
`ifdef VIDEO_CAPTURE_CRC_EN
    ,
    output logic [15:0]                            frameCrc
`endif
);

    localparam int unsigned BPL   = H_PIXELS / 8;
    localparam int unsigned DEPTH = BPL * V_LINES;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned SW    = $clog2(VSYNC_MIN + 1);
    localparam int unsigned LW    = $clog2(V_LINES + 1);
    localparam int unsigned PW    = $clog2(H_PIXELS);
    localparam int unsigned DW    = $clog2(H_BACK + 1);
    localparam int unsigned CW    = $clog2(PIXEL_DIV + 1);
    localparam int unsigned VW    = $clog2(V_BACK + 1);

    localparam logic [SW-1:0] HS_MIN = SW'(HSYNC_MIN);
    localparam logic [SW-1:0] VS_MIN = SW'(VSYNC_MIN);

    typedef enum logic [2:0] {
        StWaitVsync,
        StVblank,
        StHback,
        StCapture,
        StLineWait
    } state_e;

    // Input registers
    logic sync_q;
    logic pix_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b0;
            pix_q  <= 1'b0;
        end else begin
            sync_q <= videoSync;
            pix_q  <= videoPixel;
        end
    end

    // Sync classifier: count the high run, classify on the first low cycle.
    // The event flags are therefore valid in the cycle after the falling edge.
    logic [SW-1:0] hi_cnt_q;
    logic          hs_ev_q;
    logic          vs_ev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_cnt_q <= '0;
            hs_ev_q  <= 1'b0;
            vs_ev_q  <= 1'b0;
        end else if (sync_q) begin
            hs_ev_q <= 1'b0;
            vs_ev_q <= 1'b0;
            if (hi_cnt_q != VS_MIN) begin
                hi_cnt_q <= hi_cnt_q + 1'b1;
            end
        end else begin
            // hi_cnt_q is nonzero only in the first low cycle, so events pulse once
            hs_ev_q  <= (hi_cnt_q >= HS_MIN) && (hi_cnt_q < VS_MIN);
            vs_ev_q  <= (hi_cnt_q == VS_MIN);
            hi_cnt_q <= '0;
        end
    end

    // Frame FSM and datapath state
    state_e        state_q, state_d;
    logic [VW-1:0] vb_cnt_q, vb_cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [CW-1:0] ph_q, ph_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [6:0]    sreg_q, sreg_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic [7:0]    count_q, count_d;

    logic          sample;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          line_end;
    logic          short_line;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StWaitVsync;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vb_cnt_q  <= '0;
            line_q    <= '0;
            dly_q     <= '0;
            ph_q      <= '0;
            pix_cnt_q <= '0;
            sreg_q    <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            vb_cnt_q  <= vb_cnt_d;
            line_q    <= line_d;
            dly_q     <= dly_d;
            ph_q      <= ph_d;
            pix_cnt_q <= pix_cnt_d;
            sreg_q    <= sreg_d;
            err_q     <= err_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        vb_cnt_d   = vb_cnt_q;
        line_d     = line_q;
        dly_d      = dly_q;
        ph_d       = ph_q;
        pix_cnt_d  = pix_cnt_q;
        sreg_d     = sreg_q;
        err_d      = err_q;
        done_d     = 1'b0;
        count_d    = count_q;
        line_end   = 1'b0;
        short_line = 1'b0;

        unique case (state_q)
            StWaitVsync: begin
                // leaves only on vsync, handled below
            end
            StVblank: begin
                if (hs_ev_q) begin
                    if (vb_cnt_q == VW'(V_BACK - 1)) begin
                        state_d = StHback;
                        dly_d   = '0;
                    end else begin
                        vb_cnt_d = vb_cnt_q + 1'b1;
                    end
                end
            end
            StHback: begin
                // Entered on the cycle after t0 with dly=0, so this exit lands the
                // first CAPTURE cycle exactly on t0+H_BACK.
                if (hs_ev_q) begin
                    short_line = 1'b1;
                end else if (dly_q == DW'(H_BACK - 2)) begin
                    state_d   = StCapture;
                    ph_d      = '0;
                    pix_cnt_d = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            StCapture: begin
                if (hs_ev_q) begin
                    short_line = 1'b1;
                end else begin
                    ph_d = (ph_q == CW'(PIXEL_DIV - 1)) ? '0 : ph_q + 1'b1;
                    if (sample) begin
                        sreg_d = {sreg_q[5:0], pix_q};
                        if (pix_cnt_q == PW'(H_PIXELS - 1)) begin
                            line_end = 1'b1;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end
                end
            end
            StLineWait: begin
                if (hs_ev_q) begin
                    state_d = StHback;
                    dly_d   = '0;
                end
            end
            default: state_d = StWaitVsync;
        endcase

        // A short line advances like a complete one; its partial byte is dropped.
        if (line_end || short_line) begin
            line_d = line_q + 1'b1;
            if (short_line) begin
                err_d = 1'b1;
            end
            if (line_q == LW'(V_LINES - 1)) begin
                done_d  = 1'b1;
                count_d = count_q + 1'b1;
                state_d = StWaitVsync;
            end else if (short_line) begin
                state_d = StHback;
                dly_d   = '0;
            end else begin
                state_d = StLineWait;
            end
        end

        // Vsync from any state (re)starts the frame; an aborted frame never completes.
        if (vs_ev_q) begin
            state_d  = StVblank;
            vb_cnt_d = '0;
            line_d   = '0;
            err_d    = 1'b0;
        end
    end

    // Output / datapath-control logic
    always_comb begin
        capturing = (state_q == StHback) || (state_q == StCapture) ||
                    (state_q == StLineWait);
        sample    = (state_q == StCapture) && (ph_q == '0) && !hs_ev_q && !vs_ev_q;
        wr_en     = sample && (pix_cnt_q[2:0] == 3'b111);
        wr_addr   = AW'(32'(line_q) * BPL + 32'(pix_cnt_q) / 8);
        wr_data   = {sreg_q, pix_q};
    end

    assign frameDone  = done_q;
    assign frameCount = count_q;
    assign lineError  = err_q;

    // Frame buffer: not reset, read is registered and returns the pre-write byte
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdData <= 8'h00;
        end else if (32'(rdAddr) < DEPTH) begin
            rdData <= mem[rdAddr];
        end else begin
            rdData <= 8'h00;
        end
    end

`ifdef VIDEO_CAPTURE_CRC_EN
    // CRC-16/CCITT, poly 0x1021, MSB first
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    logic [15:0] crc_q, crc_d, frame_crc_q;

    always_comb begin
        crc_d = wr_en ? crc16_upd(crc_q, wr_data) : crc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= 16'h0000;
        end else begin
            crc_q <= vs_ev_q ? 16'hFFFF : crc_d;
            // crc_d already includes the final byte written alongside done_d
            if (done_d) begin
                frame_crc_q <= crc_d;
            end
        end
    end

    assign frameCrc = frame_crc_q;
`endif

endmodule
